// File: rtl/ncl_wavefront_driver_pkg.sv
// rtl/ncl_wavefront_driver_pkg.sv - shared types and dual-rail encodings for the NCL wavefront driver
package ncl_wavefront_driver_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA      = 2'd1,
    NULL_WAIT = 2'd2,
    ERR       = 2'd3
  } ncl_state_e;

  // One dual-rail signal: t is the true rail, f the false rail.
  typedef struct packed {
    logic t;
    logic f;
  } dr_pair_t;

  localparam dr_pair_t DR_NULL    = '{t: 1'b0, f: 1'b0};
  localparam dr_pair_t DR_DATA0   = '{t: 1'b0, f: 1'b1};
  localparam dr_pair_t DR_DATA1   = '{t: 1'b1, f: 1'b0};
  localparam dr_pair_t DR_ILLEGAL = '{t: 1'b1, f: 1'b1};

  // A pair carries a value only when exactly one rail is asserted.
  function automatic logic dr_is_data(input dr_pair_t p);
    return (p == DR_DATA0) || (p == DR_DATA1);
  endfunction

  // Both rails high is never produced by a correct threshold network.
  function automatic logic dr_is_illegal(input dr_pair_t p);
    return p == DR_ILLEGAL;
  endfunction

endpackage

// File: rtl/ncl_sync2.sv
// rtl/ncl_sync2.sv - two-flop synchronizer with synchronous reset
module ncl_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ncl_wavefront_driver.sv
// rtl/ncl_wavefront_driver.sv - drives DATA/NULL wavefronts into an NCL network and captures its result
module ncl_wavefront_driver
  import ncl_wavefront_driver_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] rail_t,
  output logic [WIDTH-1:0] rail_f,
  input  logic             ko,
  input  logic             res_t,
  input  logic             res_f,
  output logic             out_valid,
  output logic             out_data,
  output logic             err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  ncl_state_e       state;
  ncl_state_e       next_state;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_d;
  logic [CW-1:0]    wait_cnt;
  logic             ko_s;
  logic             rt_s;
  logic             rf_s;
  dr_pair_t         res_s;
  logic             accept;
  logic             capture;
  logic             timed_out;

  ncl_sync2 u_sync_ko (.clk(clk), .rst(rst), .d(ko),    .q(ko_s));
  ncl_sync2 u_sync_rt (.clk(clk), .rst(rst), .d(res_t), .q(rt_s));
  ncl_sync2 u_sync_rf (.clk(clk), .rst(rst), .d(res_f), .q(rf_s));

  assign res_s     = '{t: rt_s, f: rf_s};
  assign timed_out = (wait_cnt == CW'(TIMEOUT - 1));
  assign word_d    = accept ? in_data : word_q;

  // Wavefront sequencing; an illegal rail pair outranks completion and timeout.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (dr_is_illegal(res_s)) begin
          next_state = ERR;
        end else if (in_ready && in_valid && ko_s) begin
          accept     = 1'b1;
          next_state = DATA;
        end
      end
      DATA: begin
        if (dr_is_illegal(res_s)) begin
          next_state = ERR;
        end else if (wait_cnt == '0 && res_s != DR_NULL) begin
          // Result was already present when DATA went out: it cannot be ours.
          next_state = ERR;
        end else if (!ko_s && dr_is_data(res_s)) begin
          capture    = 1'b1;
          next_state = NULL_WAIT;
        end else if (timed_out) begin
          next_state = ERR;
        end
      end
      NULL_WAIT: begin
        if (dr_is_illegal(res_s)) begin
          next_state = ERR;
        end else if (ko_s && res_s == DR_NULL) begin
          next_state = IDLE;
        end else if (timed_out) begin
          next_state = ERR;
        end
      end
      ERR: begin
        next_state = ERR;
      end
      default: begin
        next_state = ERR;
      end
    endcase
  end

  // State register and latched operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      word_q <= '0;
    end else begin
      state  <= next_state;
      word_q <= word_d;
    end
  end

  // Rails come straight from flops so the network never sees decode glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      rail_t <= '0;
      rail_f <= '0;
    end else if (next_state == DATA) begin
      rail_t <= word_d;
      rail_f <= ~word_d;
    end else begin
      rail_t <= '0;
      rail_f <= '0;
    end
  end

  // Per-phase wait counter, restarted whenever a new phase begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (next_state != state) begin
      wait_cnt <= '0;
    end else if (state == DATA || state == NULL_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Handshake, result and error outputs, all registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 1'b0;
      err       <= 1'b0;
    end else begin
      in_ready  <= (next_state == IDLE);
      out_valid <= capture;
      err       <= (next_state == ERR);
      if (capture) begin
        out_data <= (res_s == DR_DATA1);
      end
    end
  end

endmodule

// File: tb/tb_ncl_wavefront_driver.sv
// tb/tb_ncl_wavefront_driver.sv - directed self-checking bench for ncl_wavefront_driver
module tb_ncl_wavefront_driver;

  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [WIDTH-1:0] rail_t;
  logic [WIDTH-1:0] rail_f;
  logic             ko;
  logic             res_t;
  logic             res_f;
  logic             out_valid;
  logic             out_data;
  logic             err;

  logic model_en = 1'b0;
  logic man_ko   = 1'b1;
  logic man_rt   = 1'b0;
  logic man_rf   = 1'b0;
  logic mdl_rt   = 1'b0;
  logic mdl_rf   = 1'b0;

  int checks = 0;
  int errors = 0;

  ncl_wavefront_driver #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rail_t(rail_t), .rail_f(rail_f), .ko(ko), .res_t(res_t), .res_f(res_f),
    .out_valid(out_valid), .out_data(out_data), .err(err)
  );

  always #5 clk = ~clk;

  assign ko    = model_en ? ~(mdl_rt | mdl_rf) : man_ko;
  assign res_t = model_en ? mdl_rt : man_rt;
  assign res_f = model_en ? mdl_rf : man_rf;

  function automatic logic th54w32(input logic [3:0] w);
    int s;
    s = 3 * int'(w[0]) + 2 * int'(w[1]) + int'(w[2]) + int'(w[3]);
    return s >= 5;
  endfunction

  // Threshold network with hysteresis: switches on a complete DATA or full NULL wavefront.
  always @(posedge clk) begin
    #1;
    if ((rail_t ^ rail_f) == 4'hF) begin
      mdl_rt <= th54w32(rail_t);
      mdl_rf <= !th54w32(rail_t);
    end else if (rail_t == 4'h0 && rail_f == 4'h0) begin
      mdl_rt <= 1'b0;
      mdl_rf <= 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; model_en = 1'b0;
    man_ko = 1'b1; man_rt = 1'b0; man_rf = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic accept_op(input logic [3:0] d);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 40 && !in_ready; n++) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rail_t != 4'h0 || rail_f != 4'h0) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: operand %b not accepted, got rails %b/%b expected non-null", d, rail_t, rail_f);
    end
  endtask

  task automatic wait_out_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rail_t !== 4'h0) begin errors++; $display("FAIL reset_rail_t: got %b expected 0000", rail_t); end
    checks++; if (rail_f !== 4'h0) begin errors++; $display("FAIL reset_rail_f: got %b expected 0000", rail_f); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 1'b0) begin errors++; $display("FAIL reset_out_data: got %b expected 0", out_data); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    int lat;
    bit ready_seen;
    model_en = 1'b1;
    accept_op(4'b1011);
    checks++; if (rail_t !== 4'b1011) begin errors++; $display("FAIL basic_rail_t: got %b expected 1011", rail_t); end
    checks++; if (rail_f !== 4'b0100) begin errors++; $display("FAIL basic_rail_f: got %b expected 0100", rail_f); end
    wait_out_valid(lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency: got %0d cycles expected 3", lat); end
    checks++; if (out_data !== 1'b1) begin errors++; $display("FAIL basic_out_data: got %b expected 1", out_data); end
    checks++; if (rail_t !== 4'h0 || rail_f !== 4'h0) begin errors++; $display("FAIL basic_rails_null: got %b/%b expected 0000/0000", rail_t, rail_f); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got out_valid %b expected 0", out_valid); end
    ready_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (in_ready) begin ready_seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (ready_seen !== 1'b1) begin errors++; $display("FAIL basic_return_idle: in_ready got %b expected 1", in_ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", err); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_tab;
    logic [3:0]  op;
    int lat;
    exp_tab  = 16'hA888;
    model_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      op = 4'(k);
      accept_op(op);
      wait_out_valid(lat);
      checks++;
      if (lat < 0) begin
        errors++; $display("FAIL b2b_no_result: operand %0d got no out_valid expected a pulse", k);
      end else if (out_data !== exp_tab[k]) begin
        errors++; $display("FAIL b2b_out_data: operand %0d got %b expected %b", k, out_data, exp_tab[k]);
      end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b expected 0", err); end
  endtask

  task automatic test_idle_ko_low();
    bit bad;
    int lat;
    model_en = 1'b0; man_ko = 1'b1; man_rt = 1'b0; man_rf = 1'b0;
    for (int i = 0; i < 12 && !in_ready; i++) @(negedge clk);
    man_ko = 1'b0;
    repeat (3) @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'b0110;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rail_t != 4'h0 || rail_f != 4'h0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL ko_low_no_accept: rails went non-null, got %b/%b expected 0000/0000", rail_t, rail_f); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ko_low_ready: got %b expected 1", in_ready); end
    man_ko = 1'b1;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (rail_t != 4'h0 || rail_f != 4'h0) begin lat = i; break; end
    end
    in_valid = 1'b0;
    checks++; if (lat !== 3) begin errors++; $display("FAIL ko_high_accept_latency: got %0d expected 3", lat); end
    checks++; if (rail_t !== 4'b0110 || rail_f !== 4'b1001) begin errors++; $display("FAIL ko_high_rails: got %b/%b expected 0110/1001", rail_t, rail_f); end
    do_reset();
  endtask

  task automatic test_rst_in_data();
    accept_op(4'b0101);
    checks++; if (rail_t !== 4'b0101) begin errors++; $display("FAIL rst_pre_rail_t: got %b expected 0101", rail_t); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (rail_t !== 4'h0 || rail_f !== 4'h0) begin errors++; $display("FAIL rst_rails: got %b/%b expected 0000/0000", rail_t, rail_f); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_timeout();
    int lat;
    bit bad;
    man_ko = 1'b1; man_rt = 1'b0; man_rf = 1'b0;
    accept_op(4'b1100);
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (err) begin lat = i; break; end
    end
    checks++; if (lat !== TIMEOUT) begin errors++; $display("FAIL timeout_cycles: got %0d expected %0d", lat, TIMEOUT); end
    checks++; if (rail_t !== 4'h0 || rail_f !== 4'h0) begin errors++; $display("FAIL timeout_rails: got %b/%b expected 0000/0000", rail_t, rail_f); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL timeout_ready: got %b expected 0", in_ready); end
    man_ko = 1'b0; man_rt = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid || !err) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL timeout_sticky: got err=%b out_valid=%b expected err=1 out_valid=0", err, out_valid); end
    do_reset();
  endtask

  task automatic test_illegal();
    int lat;
    bit bad;
    accept_op(4'b0011);
    man_rt = 1'b1; man_rf = 1'b1;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (err) begin lat = i; break; end
    end
    checks++; if (lat !== 3) begin errors++; $display("FAIL illegal_latency: got %0d expected 3", lat); end
    checks++; if (rail_t !== 4'h0 || rail_f !== 4'h0) begin errors++; $display("FAIL illegal_rails: got %b/%b expected 0000/0000", rail_t, rail_f); end
    man_rt = 1'b0; man_rf = 1'b0; man_ko = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (in_ready || !err) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL illegal_sticky: got in_ready=%b err=%b expected 0/1", in_ready, err); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL illegal_recover: got in_ready=%b err=%b expected 1/0", in_ready, err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_idle_ko_low();
    test_rst_in_data();
    test_timeout();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
